// File: rtl/nvm_spi_pkg.sv
// Shared opcodes, FSM states and status-register layout for the SPI EEPROM emulator.
package nvm_spi_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_READ,
    ST_RDSR,
    ST_WRITE,
    ST_IGNORE
  } state_e;

  function automatic logic [7:0] status_byte(input logic wip, input logic wel);
    logic [7:0] s;
    s         = '0;
    s[SR_WIP] = wip;
    s[SR_WEL] = wel;
    return s;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus single-clk edge pulses on sck and cs_n.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n_i,
  input  logic sck_i,
  input  logic si_i,
  output logic cs_n_o,
  output logic si_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_fall_o,
  output logic cs_rise_o
);

  logic [2:0] cs_q;
  logic [2:0] sck_q;
  logic [1:0] si_q;

  // Third flop of cs/sck holds the previous synced value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q  <= 3'b111;
      sck_q <= 3'b000;
      si_q  <= 2'b00;
    end else begin
      cs_q  <= {cs_q[1:0], cs_n_i};
      sck_q <= {sck_q[1:0], sck_i};
      si_q  <= {si_q[0], si_i};
    end
  end

  assign cs_n_o     = cs_q[1];
  assign si_o       = si_q[1];
  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign sck_fall_o = ~sck_q[1] & sck_q[2];
  assign cs_fall_o  = ~cs_q[1] & cs_q[2];
  assign cs_rise_o  = cs_q[1] & ~cs_q[2];

endmodule

// File: rtl/nvm_spi_emu.sv
// 25xx-style SPI EEPROM emulator (mode 0) with READ/WRITE/RDSR/WREN/WRDI over a sync-read memory port.
module nvm_spi_emu
  import nvm_spi_pkg::*;
#(
  parameter int ADDR_BYTES   = 2,
  parameter int MEM_AW       = 16,
  parameter int PAGE_SIZE    = 32,
  parameter int WRITE_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sck,
  input  logic              si,
  output logic              so,
  output logic              so_oe,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              busy
);

  localparam int                AB_W       = 8 * ADDR_BYTES;
  localparam int                WC_W       = $clog2(WRITE_CYCLES + 1);
  localparam logic [MEM_AW-1:0] PG_MASK    = MEM_AW'(PAGE_SIZE - 1);
  localparam logic [1:0]        ABYTE_LAST = 2'(ADDR_BYTES - 1);

  logic cs_n_s, si_s, sck_rise, sck_fall, cs_fall, cs_rise;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [1:0]        abyte_q;
  logic              wr_cmd_q, wr_any_q, wel_q;
  logic [WC_W-1:0]   wip_cnt_q;
  logic              so_q, so_oe_q, mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              rd_p0_q, rd_p1_q;
  logic [7:0]        rx_q, tx_q, pf_q;
  logic [AB_W-1:0]   addr_q;

  logic              active, wip, byte_done, addr_done, tx_start, tx_state;
  logic              wel_set, wel_clr;
  logic [7:0]        rx_byte, tx_src;
  logic [AB_W-1:0]   addr_full;

  function automatic logic [MEM_AW-1:0] page_inc(input logic [MEM_AW-1:0] a);
    return (a & ~PG_MASK) | ((a + 1'b1) & PG_MASK);
  endfunction

  spi_pin_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n_i    (cs_n),
    .sck_i     (sck),
    .si_i      (si),
    .cs_n_o    (cs_n_s),
    .si_o      (si_s),
    .sck_rise_o(sck_rise),
    .sck_fall_o(sck_fall),
    .cs_fall_o (cs_fall),
    .cs_rise_o (cs_rise)
  );

  always_comb begin
    active    = ~cs_n_s;
    wip       = (wip_cnt_q != '0);
    rx_byte   = {rx_q[6:0], si_s};
    addr_full = {addr_q[AB_W-2:0], si_s};
    byte_done = active && sck_rise && (bit_cnt_q == 3'd7);
    addr_done = byte_done && (state_q == ST_ADDR) && (abyte_q == ABYTE_LAST);
    tx_state  = (state_q == ST_READ) || (state_q == ST_RDSR);
    tx_start  = active && sck_fall && tx_state && (bit_cnt_q == 3'd0);
    tx_src    = (state_q == ST_READ) ? pf_q : status_byte(wip, wel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // While WIP is set only RDSR is decoded; everything else is parked in IGNORE.
  always_comb begin
    state_d = state_q;
    wel_set = 1'b0;
    wel_clr = 1'b0;
    if (!active) begin
      state_d = ST_IDLE;
    end else if (byte_done) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IGNORE;
          if (rx_byte == OP_RDSR) begin
            state_d = ST_RDSR;
          end else if (!wip) begin
            case (rx_byte)
              OP_READ:  state_d = ST_ADDR;
              OP_WRITE: if (wel_q) state_d = ST_ADDR;
              OP_WREN:  wel_set = 1'b1;
              OP_WRDI:  wel_clr = 1'b1;
              default:  ;
            endcase
          end
        end
        ST_ADDR: if (abyte_q == ABYTE_LAST) state_d = wr_cmd_q ? ST_WRITE : ST_READ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      abyte_q     <= '0;
      wr_cmd_q    <= 1'b0;
      wr_any_q    <= 1'b0;
      wel_q       <= 1'b0;
      wip_cnt_q   <= '0;
      so_q        <= 1'b0;
      so_oe_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_p0_q     <= 1'b0;
      rd_p1_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      rd_p0_q  <= 1'b0;
      rd_p1_q  <= rd_p0_q;
      if (wip)      wip_cnt_q  <= wip_cnt_q - 1'b1;
      if (mem_we_q) mem_addr_q <= page_inc(mem_addr_q);
      if (wel_set)  wel_q      <= 1'b1;
      if (wel_clr)  wel_q      <= 1'b0;
      if (!active) begin
        bit_cnt_q <= '0;
        abyte_q   <= '0;
        so_oe_q   <= 1'b0;
        wr_any_q  <= 1'b0;
        if (cs_rise && (state_q == ST_WRITE) && wr_any_q) begin
          wel_q     <= 1'b0;
          wip_cnt_q <= WC_W'(WRITE_CYCLES);
        end
      end else begin
        if (cs_fall) so_q <= 1'b0;
        if (sck_rise) begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          case (state_q)
            ST_IDLE: if (byte_done) wr_cmd_q <= (rx_byte == OP_WRITE);
            ST_ADDR: if (byte_done) begin
              abyte_q <= abyte_q + 1'b1;
              if (addr_done) begin
                mem_addr_q <= addr_full[MEM_AW-1:0];
                rd_p0_q    <= ~wr_cmd_q;
              end
            end
            // Prefetch the next byte early so it is ready at the next byte boundary.
            ST_READ: if (bit_cnt_q == 3'd1) begin
              mem_addr_q <= mem_addr_q + 1'b1;
              rd_p0_q    <= 1'b1;
            end
            ST_WRITE: if (byte_done) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= rx_byte;
              wr_any_q    <= 1'b1;
            end
            default: ;
          endcase
        end
        if (sck_fall && tx_state) begin
          so_oe_q <= 1'b1;
          so_q    <= tx_start ? tx_src[7] : tx_q[7];
        end
      end
    end
  end

  // Datapath shifters; cleared whenever chip select is released.
  always_ff @(posedge clk) begin
    if (!active) begin
      rx_q   <= '0;
      addr_q <= '0;
    end else if (sck_rise) begin
      rx_q <= rx_byte;
      if (state_q == ST_ADDR) addr_q <= addr_full;
    end
    if (rd_p1_q) pf_q <= mem_rdata;
    if (tx_start)                  tx_q <= {tx_src[6:0], 1'b0};
    else if (active && sck_fall)   tx_q <= {tx_q[6:0], 1'b0};
  end

  assign so        = so_q;
  assign so_oe     = so_oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = wip;

endmodule

// File: tb/tb_nvm_spi_emu.sv
// Scoreboard bench for nvm_spi_emu: SPI master tasks, sync-read memory model, write and busy monitors.
`timescale 1ns/1ps
module tb_nvm_spi_emu;

  localparam int AB = 2;
  localparam int AW = 16;
  localparam int PS = 32;
  localparam int WC = 2000;
  localparam int H  = 80;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs_n = 1'b1;
  logic          sck = 1'b0;
  logic          si = 1'b0;
  logic          so, so_oe, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata, mem_wdata;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [7:0]    exp_q[$];
  logic [7:0]    rx_q[$];
  logic [23:0]   exp_wr[$];
  logic [23:0]   wr_log[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            busy_run = 0;
  int            busy_len = 0;
  logic          oe_seen = 1'b0;

  nvm_spi_emu #(
    .ADDR_BYTES  (AB),
    .MEM_AW      (AW),
    .PAGE_SIZE   (PS),
    .WRITE_CYCLES(WC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_n     (cs_n),
    .sck      (sck),
    .si       (si),
    .so       (so),
    .so_oe    (so_oe),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      wr_log.push_back({mem_addr, mem_wdata});
    end
  end

  always @(posedge clk) begin
    if (busy) busy_run = busy_run + 1;
    else begin
      if (busy_run != 0) busy_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic spi_begin();
    cs_n = 1'b0;
    #(H);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      si = tx[i];
      #(H);
      rx[i] = so;
      if (so_oe) oe_seen = 1'b1;
      sck = 1'b1;
      #(H);
      sck = 1'b0;
    end
  endtask

  task automatic spi_end();
    #(H);
    cs_n = 1'b1;
    si   = 1'b0;
    #(2*H);
  endtask

  task automatic cmd_op(input logic [7:0] op);
    logic [7:0] r;
    spi_begin();
    spi_byte(op, 8, r);
    spi_end();
  endtask

  task automatic cmd_rdsr();
    logic [7:0] r;
    spi_begin();
    spi_byte(8'h05, 8, r);
    spi_byte(8'h00, 8, r);
    spi_end();
    rx_q.push_back(r);
  endtask

  task automatic cmd_read(input logic [15:0] a, input int n);
    logic [7:0] r;
    spi_begin();
    spi_byte(8'h03, 8, r);
    spi_byte(a[15:8], 8, r);
    spi_byte(a[7:0], 8, r);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'h00, 8, r);
      rx_q.push_back(r);
    end
    spi_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (so !== 1'b0)     begin n_bad++; $display("FAIL reset_so got %b want 0", so); end
    n_cmp++; if (so_oe !== 1'b0)  begin n_bad++; $display("FAIL reset_so_oe got %b want 0", so_oe); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== '0) begin n_bad++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== '0) begin n_bad++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_status();
    logic [7:0] e, g;
    exp_q.push_back(8'h00); cmd_rdsr();
    cmd_op(8'h06);
    exp_q.push_back(8'h02); cmd_rdsr();
    cmd_op(8'h04);
    exp_q.push_back(8'h00); cmd_rdsr();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rx_q.size() == 0) begin n_bad++; $display("FAIL status_missing want %h", e); end
      else begin
        g = rx_q.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL status_byte got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_read();
    logic [7:0] e, g;
    rx_q.delete();
    oe_seen = 1'b0;
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    cmd_read(16'h00FE, 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rx_q.size() == 0) begin n_bad++; $display("FAIL read_missing want %h", e); end
      else begin
        g = rx_q.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL read_byte got %h want %h", g, e); end
      end
    end
    n_cmp++; if (oe_seen !== 1'b1) begin n_bad++; $display("FAIL read_oe_active got %b want 1", oe_seen); end
    n_cmp++; if (so_oe !== 1'b0)   begin n_bad++; $display("FAIL read_oe_after_cs got %b want 0", so_oe); end
  endtask

  task automatic test_write_page();
    logic [7:0]  r, e, g;
    logic [23:0] ew, gw;
    int          c;
    cmd_op(8'h06);
    wr_log.delete();
    exp_wr.push_back({16'h001E, 8'hA1});
    exp_wr.push_back({16'h001F, 8'hA2});
    exp_wr.push_back({16'h0000, 8'hA3});
    spi_begin();
    spi_byte(8'h02, 8, r); spi_byte(8'h00, 8, r); spi_byte(8'h1E, 8, r);
    spi_byte(8'hA1, 8, r); spi_byte(8'hA2, 8, r); spi_byte(8'hA3, 8, r);
    spi_end();
    n_cmp++;
    if (wr_log.size() != exp_wr.size()) begin
      n_bad++; $display("FAIL page_wr_count got %0d want %0d", wr_log.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && wr_log.size() > 0) begin
      ew = exp_wr.pop_front(); gw = wr_log.pop_front(); n_cmp++;
      if (gw !== ew) begin n_bad++; $display("FAIL page_wr got %h want %h", gw, ew); end
    end
    exp_wr.delete();
    exp_q.push_back(8'h01); cmd_rdsr();
    c = 0;
    while (busy && c < 4*WC) begin @(negedge clk); c++; end
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wip_timeout busy got %b want 0", busy); end
    n_cmp++; if (busy_len != WC) begin n_bad++; $display("FAIL wip_length got %0d want %0d", busy_len, WC); end
    exp_q.push_back(8'h00); cmd_rdsr();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rx_q.size() == 0) begin n_bad++; $display("FAIL page_sr_missing want %h", e); end
      else begin
        g = rx_q.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL page_sr got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_write_no_wel();
    logic [7:0] r, e, g;
    wr_log.delete();
    oe_seen = 1'b0;
    spi_begin();
    spi_byte(8'h02, 8, r); spi_byte(8'h00, 8, r); spi_byte(8'h40, 8, r); spi_byte(8'h55, 8, r);
    spi_end();
    n_cmp++; if (wr_log.size() != 0) begin n_bad++; $display("FAIL nowel_wr_count got %0d want 0", wr_log.size()); end
    n_cmp++; if (oe_seen !== 1'b0)   begin n_bad++; $display("FAIL nowel_oe got %b want 0", oe_seen); end
    exp_q.push_back(8'h00); cmd_rdsr();
    e = exp_q.pop_front(); n_cmp++;
    if (rx_q.size() == 0) begin n_bad++; $display("FAIL nowel_sr_missing want %h", e); end
    else begin
      g = rx_q.pop_front();
      if (g !== e) begin n_bad++; $display("FAIL nowel_sr got %h want %h", g, e); end
    end
  endtask

  task automatic test_read_wrap();
    logic [7:0] e, g;
    rx_q.delete();
    exp_q.push_back(8'hFF); exp_q.push_back(8'hA3);
    cmd_read(16'hFFFF, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rx_q.size() == 0) begin n_bad++; $display("FAIL wrap_missing want %h", e); end
      else begin
        g = rx_q.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL wrap_byte got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_partial_write();
    logic [7:0]  r;
    logic [23:0] ew, gw;
    cmd_op(8'h06);
    wr_log.delete();
    exp_wr.push_back({16'h0010, 8'h5A});
    spi_begin();
    spi_byte(8'h02, 8, r); spi_byte(8'h00, 8, r); spi_byte(8'h10, 8, r);
    spi_byte(8'h5A, 8, r); spi_byte(8'hFF, 3, r);
    spi_end();
    n_cmp++;
    if (wr_log.size() != 1) begin n_bad++; $display("FAIL partial_wr_count got %0d want 1", wr_log.size()); end
    if (wr_log.size() > 0) begin
      ew = exp_wr.pop_front(); gw = wr_log.pop_front(); n_cmp++;
      if (gw !== ew) begin n_bad++; $display("FAIL partial_wr got %h want %h", gw, ew); end
    end
    exp_wr.delete();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL partial_wip got %b want 1", busy); end
  endtask

  task automatic test_wip_block();
    logic [7:0] r, e, g;
    rx_q.delete();
    oe_seen = 1'b0;
    cmd_read(16'h0000, 1);
    n_cmp++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL wip_read_oe got %b want 0", oe_seen); end
    rx_q.delete();
    oe_seen = 1'b0;
    spi_begin(); spi_byte(8'h9F, 8, r); spi_byte(8'h00, 8, r); spi_end();
    n_cmp++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL unknown_op_oe got %b want 0", oe_seen); end
    cmd_op(8'h06);
    exp_q.push_back(8'h01); cmd_rdsr();
    e = exp_q.pop_front(); n_cmp++;
    if (rx_q.size() == 0) begin n_bad++; $display("FAIL wip_sr_missing want %h", e); end
    else begin
      g = rx_q.pop_front();
      if (g !== e) begin n_bad++; $display("FAIL wip_wren_sr got %h want %h", g, e); end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wip_reset_busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] r, e, g;
    cmd_op(8'h06);
    spi_begin();
    spi_byte(8'h03, 8, r); spi_byte(8'h00, 8, r); spi_byte(8'h20, 8, r);
    spi_byte(8'h00, 3, r);
    n_cmp++; if (so_oe !== 1'b1) begin n_bad++; $display("FAIL midread_oe got %b want 1", so_oe); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (so_oe !== 1'b0) begin n_bad++; $display("FAIL midread_reset_oe got %b want 0", so_oe); end
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL midread_reset_busy got %b want 0", busy); end
    cs_n = 1'b1; sck = 1'b0; si = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rx_q.delete();
    exp_q.push_back(8'h00); cmd_rdsr();
    e = exp_q.pop_front(); n_cmp++;
    if (rx_q.size() == 0) begin n_bad++; $display("FAIL midread_sr_missing want %h", e); end
    else begin
      g = rx_q.pop_front();
      if (g !== e) begin n_bad++; $display("FAIL midread_sr got %h want %h", g, e); end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = i[7:0];
    @(negedge clk);
    test_reset();
    test_status();
    test_read();
    test_write_page();
    test_write_no_wel();
    test_read_wrap();
    test_partial_write();
    test_wip_block();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
